// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch-prediction unit.
// Two-bit saturating direction counter encoding and its update rules.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] sat_inc(input logic [1:0] value);
    return (value == ST) ? value : value + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return sat_inc(ctr);
    return (ctr == SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bpu_sat_ctr.sv
// Generic saturating up-counter: counts enabled cycles, holds at all-ones.
// One-cycle update latency; no backpressure (en is sampled every edge).
module bpu_sat_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup, edge-written update.
// Lookup never stalls; an update in the same cycle is only visible on the following cycle.
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         ENTRIES   = 16,
  parameter int         CNT_W     = 16,
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [ADDR_W-3:0]  tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             wr_en;
  logic [1:0]       ctr_d;
  logic             unused_lsbs;

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = if_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Targets are word aligned, so the low two bits are never stored.
  assign unused_lsbs = ^{upd_pc[1:0], upd_target[1:0]};

  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? {tgt_q[lk_idx], 2'b00} : if_pc + ADDR_W'(4);

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign wr_en   = upd_valid && !flush_all && (upd_hit || upd_taken);

  always_comb begin
    ctr_d = CTR_ALLOC;
    if (upd_hit) ctr_d = ctr_next(ctr_q[upd_idx], upd_taken);
  end

  // Rewriting valid/tag on a hit is a no-op, which keeps hit and allocate on one path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= WNT;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      ctr_q[upd_idx]   <= ctr_d;
      if (upd_taken) tgt_q[upd_idx] <= upd_target[ADDR_W-1:2];
    end
  end

  bpu_sat_ctr #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pred_hit),
    .count (hit_cnt)
  );

  bpu_sat_ctr #(.W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (mispredict),
    .count (mispred_cnt)
  );

endmodule

// File: tb/tb_bpu_btb.sv
// Directed bench for bpu_btb (ENTRIES=16, CNT_W=4) with a table-level reference model.
module tb_bpu_btb;

  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic [31:0] upd_pred_target = '0;
  logic        flush_all = 1'b0;
  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target;
  logic [3:0]  hit_cnt, mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  bpu_btb #(.ADDR_W(32), .ENTRIES(16), .CNT_W(4), .CTR_ALLOC(2'b10)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_pc           (if_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .flush_all       (flush_all),
    .mispredict      (mispredict),
    .hit_cnt         (hit_cnt),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one record per BTB slot, counters as plain integers.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_hit;
  int          m_mis;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 64;
  endfunction

  task automatic model_predict(input logic [31:0] pc, output logic h, output logic t,
                               output logic [31:0] tg);
    int i;
    i  = idx_of(pc);
    h  = m_valid[i] && (m_tag[i] == tag_of(pc));
    t  = h && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endtask

  function automatic logic model_mispred();
    if (!upd_valid) return 1'b0;
    if (upd_taken != upd_pred_taken) return 1'b1;
    return upd_taken && (upd_target != upd_pred_target);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_hit = 0;
    m_mis = 0;
  endtask

  task automatic model_step();
    logic        h, t;
    logic [31:0] tg;
    int          i;
    model_predict(if_pc, h, t, tg);
    if (h && m_hit < CMAX) m_hit++;
    if (model_mispred() && m_mis < CMAX) m_mis++;
    if (flush_all) begin
      for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
    end else if (upd_valid) begin
      i = idx_of(upd_pc);
      if (m_valid[i] && m_tag[i] == tag_of(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target & ~32'd3;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag_of(upd_pc);
        m_tgt[i]   = upd_target & ~32'd3;
        m_ctr[i]   = 2;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    cmp(name, act, exp);
  endtask

  always @(negedge clk) begin : compare
    logic        e_hit, e_tk;
    logic [31:0] e_tgt;
    model_predict(if_pc, e_hit, e_tk, e_tgt);
    n_vec++;
    cmp("model pred_hit",    32'(pred_hit),    32'(e_hit));
    cmp("model pred_taken",  32'(pred_taken),  32'(e_tk));
    cmp("model pred_target", pred_target,      e_tgt);
    cmp("model mispredict",  32'(mispredict),  32'(model_mispred()));
    cmp("model hit_cnt",     32'(hit_cnt),     32'(m_hit));
    cmp("model mispred_cnt", 32'(mispred_cnt), 32'(m_mis));
  end

  task automatic apply(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic upt,
                       input logic [31:0] uptgt, input logic fl);
    @(posedge clk);
    #1;
    if_pc           = pc;
    upd_valid       = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    upd_target      = utgt;
    upd_pred_taken  = upt;
    upd_pred_target = uptgt;
    flush_all       = fl;
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    apply(pc, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #150000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    check_lit("reset pred_hit",    32'(pred_hit),    32'd0);
    check_lit("reset pred_target", pred_target,      32'h4);
    check_lit("reset hit_cnt",     32'(hit_cnt),     32'd0);
    check_lit("reset mispred_cnt", 32'(mispred_cnt), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Cold lookup
    look(32'h40);
    check_lit("cold hit",    32'(pred_hit),   32'd0);
    check_lit("cold taken",  32'(pred_taken), 32'd0);
    check_lit("cold target", pred_target,     32'h44);

    // Allocate on taken
    apply(32'h40, 1, 32'h100, 1, 32'h80, 0, 32'h0, 0);
    check_lit("alloc mispredict", 32'(mispredict), 32'd1);
    look(32'h100);
    check_lit("alloc mispred_cnt", 32'(mispred_cnt), 32'd1);
    check_lit("alloc hit",         32'(pred_hit),    32'd1);
    check_lit("alloc taken",       32'(pred_taken),  32'd1);
    check_lit("alloc target",      pred_target,      32'h80);
    look(32'h100);
    check_lit("alloc hit_cnt", 32'(hit_cnt), 32'd1);

    // Hysteresis: 10 -> 01 -> 00, saturate, then 01 -> 10
    apply(32'h40, 1, 32'h100, 0, 32'h0, 1, 32'h80, 0);
    apply(32'h40, 1, 32'h100, 0, 32'h0, 1, 32'h80, 0);
    look(32'h100);
    check_lit("snt taken",  32'(pred_taken), 32'd0);
    check_lit("snt target", pred_target,     32'h104);
    apply(32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    apply(32'h40, 1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    look(32'h100);
    check_lit("snt hold taken", 32'(pred_taken), 32'd0);
    check_lit("snt hold hit",   32'(pred_hit),   32'd1);
    apply(32'h40, 1, 32'h100, 1, 32'h80, 0, 32'h0, 0);
    look(32'h100);
    check_lit("wnt taken", 32'(pred_taken), 32'd0);
    apply(32'h40, 1, 32'h100, 1, 32'h80, 0, 32'h0, 0);
    look(32'h100);
    check_lit("wt taken",  32'(pred_taken), 32'd1);
    check_lit("wt target", pred_target,     32'h80);

    // Aliasing on index 0 and miss-not-taken leaves entry untouched
    apply(32'h40, 1, 32'h140, 1, 32'h200, 0, 32'h0, 0);
    look(32'h100);
    check_lit("alias old miss",   32'(pred_hit), 32'd0);
    check_lit("alias old target", pred_target,   32'h104);
    look(32'h140);
    check_lit("alias new hit",    32'(pred_hit), 32'd1);
    check_lit("alias new target", pred_target,   32'h200);
    apply(32'h40, 1, 32'h180, 0, 32'h0, 0, 32'h0, 0);
    check_lit("nt miss mispredict", 32'(mispredict), 32'd0);
    look(32'h140);
    check_lit("no-alloc target", pred_target, 32'h200);

    // Same-cycle update/lookup shows pre-update contents
    apply(32'h140, 1, 32'h140, 0, 32'h0, 1, 32'h200, 0);
    check_lit("bypass taken",  32'(pred_taken), 32'd1);
    check_lit("bypass target", pred_target,     32'h200);
    look(32'h140);
    check_lit("post taken",  32'(pred_taken), 32'd0);
    check_lit("post target", pred_target,     32'h144);

    // Flush beats a taken update
    apply(32'h40, 1, 32'h240, 1, 32'h300, 0, 32'h0, 1);
    look(32'h240);
    check_lit("flush no-alloc",     32'(pred_hit),    32'd0);
    check_lit("flush mispred_cnt",  32'(mispred_cnt), 32'd8);
    look(32'h140);
    check_lit("flush invalidates", 32'(pred_hit), 32'd0);
    check_lit("flush hit_cnt",     32'(hit_cnt),  32'd10);
    look(32'hFFFF_FFFC);
    check_lit("wrap target", pred_target, 32'h0);

    // Counter saturation
    for (int k = 0; k < 20; k++) apply(32'h40, 1, 32'h400, 0, 32'h0, 1, 32'h0, 0);
    look(32'h40);
    check_lit("sat mispred_cnt", 32'(mispred_cnt), 32'd15);

    // Asynchronous reset between edges drops a pending write
    apply(32'h40, 1, 32'h100, 1, 32'h80, 0, 32'h0, 0);
    look(32'h100);
    check_lit("pre-reset hit", 32'(pred_hit), 32'd1);
    @(posedge clk);
    #2;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h500;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    #1 rst = 1'b0;
    #1;
    check_lit("async hit",         32'(pred_hit),    32'd0);
    check_lit("async taken",       32'(pred_taken),  32'd0);
    check_lit("async target",      pred_target,      32'h104);
    check_lit("async hit_cnt",     32'(hit_cnt),     32'd0);
    check_lit("async mispred_cnt", 32'(mispred_cnt), 32'd0);
    check_lit("async mispredict",  32'(mispredict),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    upd_valid = 1'b0;
    look(32'h100);
    check_lit("after reset miss", 32'(pred_hit), 32'd0);
    look(32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpu_btb.md
Name: bpu_btb

Overview:
- Parametrised branch-prediction unit for the 5-stage pipeline: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Lookup is combinational against the IF-stage PC and drives the pcmux "predicted next PC".
- Update arrives from branch resolution (ID stage) and writes on the clock edge.
- Reports mispredicts to the flush logic and keeps saturating performance counters.

Parameters:
- ADDR_W, 32: PC width.
- ENTRIES, 16: BTB depth; must be a power of 2 and ≥2. IDX_W = log2(ENTRIES) is a derived localparam.
- CNT_W, 16: width of each performance counter.
- CTR_ALLOC, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_pc  in  ADDR_W  PC being fetched.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit && counter[1].
- pred_target  out  ADDR_W  stored target if pred_taken, else if_pc+4.
- upd_valid  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual target; meaningful only when upd_taken=1.
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  ADDR_W  predicted target carried down the pipe.
- flush_all  in  1  invalidate every entry (context change / IM reload).
- mispredict  out  1  combinational, asserted in the upd_valid cycle.
- hit_cnt  out  CNT_W  lookups with pred_hit=1, saturating.
- mispred_cnt  out  CNT_W  mispredicts, saturating.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Per-entry storage: valid, tag, target[ADDR_W-1:2] (low 2 bits always reconstructed as 0), ctr[1:0].
- Reset (rst=0, asynchronous, effective immediately without a clock):
  - all valid=0, all ctr=2'b01, hit_cnt=0, mispred_cnt=0.
  - Consequently pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict follows its equation.
- Lookup: purely combinational, zero latency. No bypass: if an update writes the same index in the same cycle, the lookup returns pre-update contents.
- Mispredict:
  - mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
  - 0 when upd_valid=0.
- Update on the clock edge when upd_valid=1 and flush_all=0:
  - Hit (valid && tag match): ctr increments on taken, decrements on not-taken, saturating at 2'b11 / 2'b00. Target is overwritten when taken.
  - Miss and taken: allocate/replace the entry with valid=1, tag, target, ctr=CTR_ALLOC.
  - Miss and not-taken: no write.
- flush_all=1: all valid bits clear on the next edge. Counters and targets are left stale. Flush beats a simultaneous update, so nothing is allocated. Perf counters are not cleared.
- Perf counters:
  - hit_cnt += 1 each cycle pred_hit=1.
  - mispred_cnt += 1 each cycle mispredict=1.
  - Both hold at 2^CNT_W-1 and never wrap.
- Arithmetic: pred_target = if_pc+4 is mod 2^ADDR_W; wraps 0xFFFF_FFFC -> 0x0000_0000.
- Reset mid-update: reset wins; the pending write is lost.

Decomposition:
- Package bpu_pkg:
  - ctr state constants: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - functions ctr_next(ctr, taken) and sat_inc(value).
- One sub-module, bpu_sat_ctr: a generic saturating up-counter (parameter W, inputs en, async active-low rst), instantiated twice for the perf counters.
- BTB array and tag compare stay inline in bpu_btb.

Test Plan (ENTRIES=16, CNT_W=4):
1. Cold lookup: after reset, if_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044; both counters 0.
2. Allocate on taken: update upd_pc=0x100, taken=1, upd_target=0x80, upd_pred_taken=0 -> mispredict=1 that cycle, mispred_cnt=1. Next cycle if_pc=0x100 -> hit=1, taken=1, target=0x80, hit_cnt increments.
3. Counter hysteresis:
   - Two not-taken updates at 0x100 -> ctr 10->01->00; lookup gives hit=1, taken=0, target=0x104.
   - Two more not-taken -> stays 00.
   - Then two taken -> 01, 10; taken=1 again.
4. Aliasing, upd_target change, and no-allocate:
   - Taken update at 0x140 (same index 0) with target 0x200 -> lookup 0x100 misses; lookup 0x140 hits, target 0x200.
   - A not-taken update at 0x180 (miss) leaves index 0 unchanged.
5. Simultaneous events:
   - Update and lookup on the same pc in the same cycle -> lookup shows pre-update values; post-update values appear the next cycle.
   - flush_all with a taken update -> next lookup misses; hit_cnt unchanged.
6. Saturation and asynchronous reset:
   - 20 consecutive mispredicting updates -> mispred_cnt=15, no wrap.
   - Drop rst between clock edges -> outputs clear immediately; after release, if_pc=0x100 misses.
